// File: rtl/wb_pkg.sv
// wb_pkg: shared state type, tile geometry and beat-count helper for the write-back buffer.
package wb_pkg;
   localparam int TILE_W = 2048;
   localparam int PIX_W = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DONE = 2'd2} wb_state_e;
   function automatic int nbeats(input int beat_w);
      return TILE_W / beat_w;
   endfunction
endpackage

// File: rtl/wb_tile_slot.sv
// wb_tile_slot: one captured tile plus its destination address, read out one beat at a time.
module wb_tile_slot import wb_pkg::*; #(
   parameter int ADDR_W = 25,
   parameter int BEAT_W = 256
) (
   input  logic              clk_i,
   input  logic              load_i,
   input  logic [TILE_W-1:0] tile_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [2:0]        beat_sel_i,
   output logic [BEAT_W-1:0] beat_o,
   output logic [ADDR_W-1:0] addr_o
);
   logic [TILE_W-1:0] tile_q;
   logic [ADDR_W-1:0] addr_q;
   always_ff @(posedge clk_i)
      if (load_i) begin
         tile_q <= tile_i;
         addr_q <= addr_i;
      end
   // beat k starts at pixel k*BEAT_W/PIX_W, lowest pixel in the LSBs
   assign beat_o = tile_q[int'(beat_sel_i) * (BEAT_W / PIX_W) * PIX_W +: BEAT_W];
   assign addr_o = addr_q;
endmodule

// File: rtl/write_back_buffer.sv
// write_back_buffer: holds 8x8 result tiles and writes each as one 8-beat DDR3 burst.
// Define WB_DOUBLE_BUF_EN for a two-slot ping-pong FIFO; the default build has one slot.
module write_back_buffer import wb_pkg::*; #(
   parameter int ADDR_W = 25,
   parameter int BEAT_W = 256
) (
   input  logic                iCLK,
   input  logic                iRST_n,
   input  logic                iValid,
   output logic                oReady,
   input  logic [TILE_W-1:0]   iTile,
   input  logic [ADDR_W-1:0]   iAddr,
   output logic                oDone,
   output logic                oBusy,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_write,
   output logic [BEAT_W-1:0]   avm_writedata,
   output logic [3:0]          avm_burstcount,
   output logic [BEAT_W/8-1:0] avm_byteenable,
   input  logic                avm_waitrequest
);
`ifdef WB_DOUBLE_BUF_EN
   localparam int NSLOT = 2;
`else
   localparam int NSLOT = 1;
`endif
   localparam int NBEATS = nbeats(BEAT_W);
   localparam logic [2:0] LAST_BEAT = 3'(NBEATS - 1);
   localparam logic [3:0] BURST_LEN = 4'(NBEATS);
   wb_state_e state_q, state_d;
   logic [NSLOT-1:0] full_q, full_d, load, rd_mask, wr_mask;
   logic wr_q, wr_d, rd_q, rd_d;
   logic [2:0] beat_q, beat_d;
   logic cap, acc, last, done, pend;
   logic [BEAT_W-1:0] slot_beat [NSLOT];
   logic [ADDR_W-1:0] slot_addr [NSLOT];
   logic [BEAT_W-1:0] cur_beat;
   logic [ADDR_W-1:0] cur_addr;
   for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      assign rd_mask[i] = rd_q == 1'(i);
      assign wr_mask[i] = wr_q == 1'(i);
      assign load[i] = cap & wr_mask[i];
      wb_tile_slot #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) u_slot (
         .clk_i      (iCLK),
         .load_i     (load[i]),
         .tile_i     (iTile),
         .addr_i     (iAddr),
         .beat_sel_i (beat_q),
         .beat_o     (slot_beat[i]),
         .addr_o     (slot_addr[i])
      );
   end
   assign cur_beat = (NSLOT > 1 && rd_q) ? slot_beat[NSLOT-1] : slot_beat[0];
   assign cur_addr = (NSLOT > 1 && rd_q) ? slot_addr[NSLOT-1] : slot_addr[0];
   assign oReady = iRST_n & ~&full_q;
   assign cap = iValid & oReady;
   assign acc = avm_write & ~avm_waitrequest;
   assign last = acc && beat_q == LAST_BEAT;
   assign done = state_q == DONE;
   // a tile is waiting behind the one in flight, or arrives this very cycle
   assign pend = |(full_q & ~rd_mask) | cap;
   always_comb begin
      full_d = (full_q & ~(rd_mask & {NSLOT{done}})) | (wr_mask & {NSLOT{cap}});
      wr_d = (NSLOT > 1) ? wr_q ^ cap : 1'b0;
      rd_d = (NSLOT > 1) ? rd_q ^ done : 1'b0;
      beat_d = acc ? beat_q + 3'd1 : beat_q;
      state_d = (state_q == BURST) ? (last ? DONE : BURST) : (pend ? BURST : IDLE);
   end
   always_ff @(posedge iCLK or negedge iRST_n)
      if (!iRST_n) begin
         state_q <= IDLE;
         full_q <= '0;
         wr_q <= 1'b0;
         rd_q <= 1'b0;
         beat_q <= '0;
      end else begin
         state_q <= state_d;
         full_q <= full_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         beat_q <= beat_d;
      end
   assign avm_write = state_q == BURST;
   assign avm_address = avm_write ? cur_addr : '0;
   assign avm_writedata = avm_write ? cur_beat : '0;
   assign avm_burstcount = avm_write ? BURST_LEN : 4'd0;
   assign avm_byteenable = '1;
   assign oDone = done;
   assign oBusy = state_q != IDLE || |full_q;
endmodule
